// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller:
// state encoding, multdiv timeout default and the nop instruction word.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int          MD_TIMEOUT_DEF = 48;
  localparam logic [31:0] NOP_INSN       = 32'h0;

endpackage

// File: rtl/md_timeout_timer.sv
// 8-bit saturating wait timer for the multdiv unit.
// Ports: clock, reset (sync, active-high), i_clr, i_inc, o_expired.
module md_timeout_timer
  import pipe_ctrl_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'(MD_TIMEOUT_DEF - 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc && r_cnt != 8'hff) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expired = (r_cnt >= LIMIT);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Latch enables, bubbles, flushes and multdiv launch/wait sequencing.
// Ports: clock/reset, hazard/redirect/md inputs; PC..MW enables, nop
// controls, md_go/md_abort/md_busy; perf counters with PIPE_PERF_CNT_EN.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic is_data_hazard,
  input  logic x_redirect,
  input  logic dx_is_md,
  input  logic md_ready,
  input  logic md_exception,
  output logic pc_en,
  output logic fd_en,
  output logic dx_en,
  output logic xm_en,
  output logic mw_en,
  output logic fd_flush,
  output logic dx_nop,
  output logic xm_nop,
  output logic xm_sel_md,
  output logic md_go,
  output logic md_abort,
  output logic md_busy
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [7:0] LP_LIMIT = 8'(MD_TIMEOUT - 1);

  state_e r_state;
  state_e w_next;
  logic   w_expired;
  logic   w_unused_exc;

  // exception travels with the result; writeback deals with it
  assign w_unused_exc = md_exception;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  md_timeout_timer #(
    .LIMIT(LP_LIMIT)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clr    (r_state == RUN),
    .i_inc    (r_state == MD_WAIT),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next    = RUN;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    xm_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_nop    = 1'b0;
    xm_nop    = 1'b0;
    xm_sel_md = 1'b0;
    md_go     = 1'b0;
    md_abort  = 1'b0;
    md_busy   = 1'b0;
    if (!reset) begin
      unique case (r_state)
        RUN: begin
          if (dx_is_md) begin
            md_go  = 1'b1;
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_nop = 1'b1;
            w_next = MD_WAIT;
          end else if (x_redirect) begin
            fd_flush = 1'b1;
            dx_nop   = 1'b1;
          end else if (is_data_hazard) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_nop = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          if (md_ready) begin
            xm_sel_md = 1'b1;
          end else if (w_expired) begin
            // md insn dropped: XM gets a bubble, DX refilled with a nop
            md_abort = 1'b1;
            dx_nop   = 1'b1;
            xm_nop   = 1'b1;
          end else begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_nop = 1'b1;
            w_next = MD_WAIT;
          end
        end
        default: w_next = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!pc_en) r_stall <= r_stall + CNT_W'(1);
      if (fd_flush) r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
`endif

endmodule
